pulse_holder: RTL and testbench

PULSE_HOLDER -- requirements
Module: pulse_holder

---
 rtl/pulse_holder.sv | 84 ++++++++
 tb/tb_pulse_holder.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/pulse_holder.sv
// pulse_holder: holds out high for a switch-weighted number of prescaled units per write edge.
// Define PULSE_HOLDER_EXTEND_EN to let a new trigger during a hold extend it.
module pulse_holder #(
  parameter int NUM_SW = 4,
  parameter int W_W = 9,
  parameter logic [NUM_SW*W_W-1:0] WEIGHTS = {9'd32, 9'd56, 9'd80, 9'd88},
  parameter int CNT_W = 12,
  parameter int PRESCALE = 1
) (
  input  logic              sysclk,
  input  logic              rst,
  input  logic              write,
  input  logic [NUM_SW-1:0] sw,
  input  logic              abort,
  output logic              out,
  output logic              done,
  output logic [CNT_W-1:0]  remaining
);
  localparam int RW = CNT_W + 4;
  localparam int PW = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
  localparam logic [RW-1:0] MAX = {4'd0, {CNT_W{1'b1}}};
  typedef enum logic [1:0] {IDLE, HOLD, DONE} state_t;
  state_t state;
  logic write_q, trig, wrap;
  logic [PW-1:0] pcnt;
  logic [RW-1:0] raw;
  logic [CNT_W-1:0] sum, nxt;
  assign trig = write & ~write_q;
  assign wrap = pcnt == PW'(PRESCALE - 1);
  always_comb begin
    raw = '0;
    for (int i = 0; i < NUM_SW; i++) raw = raw + (sw[i] ? RW'(WEIGHTS[i*W_W +: W_W]) : '0);
    sum = raw > MAX ? '1 : raw[CNT_W-1:0];
  end
`ifdef PULSE_HOLDER_EXTEND_EN
  logic [RW-1:0] ext;
  always_comb begin
    ext = RW'(remaining - CNT_W'(wrap)) + (trig && |sw ? RW'(sum) : '0);
    nxt = ext > MAX ? '1 : ext[CNT_W-1:0];
  end
`else
  assign nxt = remaining - CNT_W'(wrap);
`endif
  // write_q resets high so a write level held through reset is not an edge
  always_ff @(posedge sysclk) begin
    if (rst) begin
      state <= IDLE;
      out <= 1'b0;
      done <= 1'b0;
      remaining <= '0;
      pcnt <= '0;
      write_q <= 1'b1;
    end else begin
      write_q <= write;
      done <= 1'b0;
      case (state)
        IDLE:
          if (trig && |sw) begin
            state <= HOLD;
            remaining <= sum;
            pcnt <= '0;
            out <= 1'b1;
          end
        HOLD:
          if (abort) begin
            state <= IDLE;
            out <= 1'b0;
            remaining <= '0;
            pcnt <= '0;
          end else begin
            pcnt <= wrap ? '0 : pcnt + 1'b1;
            remaining <= nxt;
            if (nxt == '0) begin
              state <= DONE;
              out <= 1'b0;
              done <= 1'b1;
            end
          end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_pulse_holder.sv
// tb_pulse_holder: scoreboard bench; expected hold lengths queued by stimulus, checked on each out fall.
module tb_pulse_holder;
  logic sysclk = 0, rst = 1, abort = 0, chk_idle = 0, fin = 0;
  logic [2:0] w = '0;
  logic [3:0] sw = '0;
  logic [2:0] out_v, done_v;
  logic [11:0] r0, r2;
  logic [5:0] r1;
  typedef struct {int id; int len; bit dn;} exp_t;
  exp_t q[$];
  exp_t e;
  int run[3];
  int checks = 0, fails = 0;
`ifdef PULSE_HOLDER_EXTEND_EN
  localparam int EXT_LEN = 120;
`else
  localparam int EXT_LEN = 88;
`endif

  always #5 sysclk = ~sysclk;

  pulse_holder u0 (.sysclk(sysclk), .rst(rst), .write(w[0]), .sw(sw), .abort(abort),
                   .out(out_v[0]), .done(done_v[0]), .remaining(r0));
  pulse_holder #(.CNT_W(6)) u1 (.sysclk(sysclk), .rst(rst), .write(w[1]), .sw(sw), .abort(abort),
                   .out(out_v[1]), .done(done_v[1]), .remaining(r1));
  pulse_holder #(.PRESCALE(4)) u2 (.sysclk(sysclk), .rst(rst), .write(w[2]), .sw(sw), .abort(abort),
                   .out(out_v[2]), .done(done_v[2]), .remaining(r2));

  always @(negedge sysclk) begin
    for (int k = 0; k < 3; k++) begin
      int rv;
      rv = k == 0 ? int'(r0) : k == 1 ? int'(r1) : int'(r2);
      if (chk_idle) begin
        checks++;
        if (out_v[k] || done_v[k] || rv != 0) begin
          fails++;
          $display("FAIL idle%0d: out %0b done %0b rem %0d, required 0 0 0", k, out_v[k], done_v[k], rv);
        end
      end
      if (out_v[k]) run[k]++;
      else if (run[k] != 0) begin
        checks++;
        if (q.size() == 0) begin
          fails++;
          $display("FAIL hold%0d: unexpected %0d-cycle hold, required none", k, run[k]);
        end else begin
          e = q.pop_front();
          if (e.id != k || e.len != run[k] || e.dn != done_v[k] || rv != 0) begin
            fails++;
            $display("FAIL hold%0d: len %0d done %0b rem %0d, required dut %0d len %0d done %0b rem 0",
                     k, run[k], done_v[k], rv, e.id, e.len, e.dn);
          end
        end
        run[k] = 0;
      end else if (done_v[k]) begin
        checks++;
        fails++;
        $display("FAIL stray_done%0d: done 1 with no hold ending, required 0", k);
      end
    end
    if (fin) begin
      checks++;
      if (q.size() != 0) begin
        fails++;
        $display("FAIL pending: %0d holds not seen, required 0", q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
    end
  end

  task automatic pulse(input int k);
    @(posedge sysclk); #1 w[k] = 1;
    @(posedge sysclk); #1 w[k] = 0;
  endtask

  task automatic expect_hold(input int id, input int len, input bit dn);
    exp_t x;
    x.id = id; x.len = len; x.dn = dn;
    q.push_back(x);
  endtask

  task automatic idle_check();
    @(posedge sysclk); #1 chk_idle = 1;
    @(posedge sysclk); #1 chk_idle = 0;
  endtask

  initial begin
    repeat (3) @(posedge sysclk);
    #1 rst = 0;
    idle_check();
    // single 88-cycle hold, then a trigger landing in DONE that must be ignored
    sw = 4'b0001; expect_hold(0, 88, 1); pulse(0);
    repeat (100) @(posedge sysclk);
    expect_hold(0, 88, 1); pulse(0);
    repeat (87) @(posedge sysclk);
    pulse(0);
    repeat (10) @(posedge sysclk);
    idle_check();
    sw = 4'b0000; pulse(0);
    repeat (5) @(posedge sysclk);
    idle_check();
    sw = 4'b1111; expect_hold(0, 256, 1); pulse(0);
    repeat (270) @(posedge sysclk);
    // write held high: one hold only, then a fresh edge retriggers
    sw = 4'b0001; expect_hold(0, 88, 1);
    @(posedge sysclk); #1 w[0] = 1;
    repeat (500) @(posedge sysclk);
    #1 w[0] = 0;
    expect_hold(0, 88, 1); pulse(0);
    repeat (100) @(posedge sysclk);
    expect_hold(0, 10, 0); pulse(0);
    repeat (9) @(posedge sysclk);
    #1 abort = 1;
    @(posedge sysclk); #1 abort = 0;
    repeat (5) @(posedge sysclk);
    idle_check();
    // abort high in IDLE at the trigger edge must not block the hold
    expect_hold(0, 88, 1);
    @(posedge sysclk); #1 abort = 1; w[0] = 1;
    @(posedge sysclk); #1 abort = 0; w[0] = 0;
    repeat (100) @(posedge sysclk);
    expect_hold(0, EXT_LEN, 1); pulse(0);
    sw = 4'b1000;
    repeat (18) @(posedge sysclk);
    pulse(0);
    repeat (130) @(posedge sysclk);
    sw = 4'b1111; expect_hold(1, 63, 1); pulse(1);
    repeat (70) @(posedge sysclk);
    sw = 4'b0100; expect_hold(2, 224, 1); pulse(2);
    repeat (230) @(posedge sysclk);
    expect_hold(2, 50, 0); pulse(2);
    repeat (49) @(posedge sysclk);
    #1 rst = 1;
    @(posedge sysclk); #1 rst = 0;
    repeat (5) @(posedge sysclk);
    idle_check();
    sw = 4'b0001; expect_hold(2, 352, 1); pulse(2);
    repeat (360) @(posedge sysclk);
    // write raised together with reset and held after it: no trigger
    @(posedge sysclk); #1 rst = 1; w[0] = 1;
    repeat (3) @(posedge sysclk);
    #1 rst = 0;
    repeat (5) @(posedge sysclk);
    idle_check();
    #1 w[0] = 0;
    for (int i = 0; i < 2000 && q.size() != 0; i++) @(posedge sysclk);
    repeat (3) @(posedge sysclk);
    #1 fin = 1;
  end
endmodule
